// File: rtl/count_monitor.sv
// count_monitor: watches the value of an upstream mod-MODULUS counter that
// runs on the same clock. It locks after LOCK_RUN legal steps in a row. While
// locked it pulses wrap on each wrap (MODULUS-1 -> 0) and counts those wraps.
// An illegal step while locked sets a sticky error flag and counts the fault.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_UNLOCKED | after reset; counting legal steps toward lock
// ST_LOCKED   | counter tracked; wraps reported, any illegal step is a fault
// ST_FAULT    | lost lock after a fault; counting legal steps toward relock
module count_monitor #(
  parameter int MODULUS  = 5,
  parameter int LOCK_RUN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] q,
  output logic       wrap,
  output logic [7:0] wraps,
  output logic       locked,
  output logic       err,
  output logic [3:0] errcnt
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Compare in 4 bits so that MODULUS = 8 works without overflowing 3 bits.
  localparam logic [3:0] MOD      = MODULUS[3:0];
  localparam logic [3:0] LAST     = MOD - 4'd1;
  localparam logic [2:0] RUN_GOAL = LOCK_RUN[2:0];

  state_t     state;
  logic [2:0] prev;
  logic       pv;
  logic [2:0] run;

  logic [3:0] q_ext;
  logic [3:0] prev_ext;
  logic [3:0] nxt;
  logic       legal;
  logic       illegal;
  logic       is_wrap;
  logic [2:0] run_inc;

  // Classify the current step against the value captured last cycle.
  always_comb begin
    q_ext    = {1'b0, q};
    prev_ext = {1'b0, prev};
    nxt      = (prev_ext == LAST) ? 4'd0 : prev_ext + 4'd1;
    legal    = pv && (q_ext < MOD) && (prev_ext < MOD) && (q_ext == nxt);
    illegal  = pv && !legal;
    is_wrap  = legal && (prev_ext == LAST) && (q == 3'd0);
    run_inc  = run + 3'd1;
  end

  // Lock FSM together with all registered outputs. Reset overrides any
  // coincident wrap or fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_UNLOCKED;
      prev   <= 3'd0;
      pv     <= 1'b0;
      run    <= 3'd0;
      wrap   <= 1'b0;
      wraps  <= 8'd0;
      locked <= 1'b0;
      err    <= 1'b0;
      errcnt <= 4'd0;
    end else begin
      prev <= q;
      pv   <= 1'b1;
      wrap <= 1'b0;
      case (state)
        ST_UNLOCKED, ST_FAULT: begin
          if (legal) begin
            if (run_inc == RUN_GOAL) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
              run    <= 3'd0;
            end else begin
              run <= run_inc;
            end
          end else if (illegal) begin
            run <= 3'd0;
          end
        end
        ST_LOCKED: begin
          if (illegal) begin
            state  <= ST_FAULT;
            locked <= 1'b0;
            err    <= 1'b1;
            run    <= 3'd0;
            if (errcnt != 4'hF) errcnt <= errcnt + 4'd1;
          end else if (is_wrap) begin
            wrap <= 1'b1;
            if (wraps != 8'hFF) wraps <= wraps + 8'd1;
          end
        end
        default: begin
          state  <= ST_UNLOCKED;
          locked <= 1'b0;
          run    <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with the default parameters MODULUS=5 and
// LOCK_RUN=3. Each cycle q is driven 1 ns after a rising edge. The outputs are
// read 1 ns after the next rising edge, which is the edge that sampled that q.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] q;
  logic       wrap;
  logic [7:0] wraps;
  logic       locked;
  logic       err;
  logic [3:0] errcnt;

  int errors = 0;
  int checks = 0;

  count_monitor #(.MODULUS(5), .LOCK_RUN(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .q      (q),
    .wrap   (wrap),
    .wraps  (wraps),
    .locked (locked),
    .err    (err),
    .errcnt (errcnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [2:0] v);
    q = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (15) cyc(3'd0);
    reset = 1'b0;
  endtask

  // After this task the monitor is locked, with prev = 3 and wraps = 0.
  task automatic lock_up();
    do_reset();
    cyc(3'd0);
    cyc(3'd1);
    cyc(3'd2);
    cyc(3'd3);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_up: locked=%0b expected 1", locked);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wrap, wraps, locked, err, errcnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: wrap=%0b wraps=%0d locked=%0b err=%0b errcnt=%0d expected all 0",
               wrap, wraps, locked, err, errcnt);
    end
  endtask

  task automatic test_lock_wrap();
    do_reset();
    cyc(3'd0);
    cyc(3'd1);
    cyc(3'd2);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: locked=%0b expected 0", locked);
    end
    cyc(3'd3);
    checks++;
    if (locked !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL lock_third_step: locked=%0b wrap=%0b expected 1 0", locked, wrap);
    end
    cyc(3'd4);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL no_wrap_at_4: wrap=%0b expected 0", wrap);
    end
    cyc(3'd0);
    checks++;
    if (wrap !== 1'b1 || wraps !== 8'd1) begin
      errors++;
      $display("FAIL first_wrap: wrap=%0b wraps=%0d expected 1 1", wrap, wraps);
    end
    cyc(3'd1);
    checks++;
    if (wrap !== 1'b0 || wraps !== 8'd1) begin
      errors++;
      $display("FAIL wrap_one_cycle: wrap=%0b wraps=%0d expected 0 1", wrap, wraps);
    end
  endtask

  task automatic test_hold_fault();
    lock_up();
    cyc(3'd4);
    cyc(3'd0);
    cyc(3'd1);
    cyc(3'd2);
    cyc(3'd2);
    checks++;
    if (locked !== 1'b0 || err !== 1'b1 || errcnt !== 4'd1) begin
      errors++;
      $display("FAIL hold_fault: locked=%0b err=%0b errcnt=%0d expected 0 1 1", locked, err, errcnt);
    end
    cyc(3'd3);
    cyc(3'd4);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: locked=%0b expected 0", locked);
    end
    cyc(3'd0);
    checks++;
    if (locked !== 1'b1 || err !== 1'b1 || wrap !== 1'b0 || wraps !== 8'd1) begin
      errors++;
      $display("FAIL relock_on_wrap_step: locked=%0b err=%0b wrap=%0b wraps=%0d expected 1 1 0 1",
               locked, err, wrap, wraps);
    end
  endtask

  task automatic test_bad_value();
    int wrap_seen;
    lock_up();
    wrap_seen = 0;
    cyc(3'd6);
    checks++;
    if (locked !== 1'b0 || err !== 1'b1 || errcnt !== 4'd1) begin
      errors++;
      $display("FAIL bad_value_fault: locked=%0b err=%0b errcnt=%0d expected 0 1 1", locked, err, errcnt);
    end
    cyc(3'd4);
    wrap_seen += int'(wrap);
    cyc(3'd0);
    wrap_seen += int'(wrap);
    cyc(3'd1);
    wrap_seen += int'(wrap);
    checks++;
    if (wrap_seen != 0) begin
      errors++;
      $display("FAIL bad_value_no_wrap: wrap pulses=%0d expected 0", wrap_seen);
    end
    cyc(3'd2);
    checks++;
    if (locked !== 1'b1 || errcnt !== 4'd1) begin
      errors++;
      $display("FAIL bad_value_relock: locked=%0b errcnt=%0d expected 1 1", locked, errcnt);
    end
  endtask

  task automatic test_wraps_saturate();
    int pulses;
    lock_up();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(3'd4);
      cyc(3'd0);
      pulses += int'(wrap);
      if (i == 254) begin
        checks++;
        if (wraps !== 8'd255) begin
          errors++;
          $display("FAIL wraps_reach_255: wraps=%0d expected 255", wraps);
        end
      end
      cyc(3'd1);
      cyc(3'd2);
      cyc(3'd3);
    end
    checks++;
    if (pulses != 300) begin
      errors++;
      $display("FAIL wrap_pulses: pulses=%0d expected 300", pulses);
    end
    checks++;
    if (wraps !== 8'd255 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wraps_saturated: wraps=%0d locked=%0b expected 255 1", wraps, locked);
    end
  endtask

  task automatic test_reset_priority();
    lock_up();
    cyc(3'd4);
    reset = 1'b1;
    cyc(3'd0);
    reset = 1'b0;
    checks++;
    if (wrap !== 1'b0 || wraps !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_wrap: wrap=%0b wraps=%0d locked=%0b expected 0 0 0", wrap, wraps, locked);
    end
    cyc(3'd1);
    cyc(3'd2);
    cyc(3'd3);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_needs_fresh_run: locked=%0b expected 0", locked);
    end
    cyc(3'd4);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_after_reset: locked=%0b expected 1", locked);
    end
  endtask

  task automatic test_errcnt_saturate();
    int exp_cnt;
    lock_up();
    for (int i = 0; i < 16; i++) begin
      cyc(3'd3);
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (errcnt !== exp_cnt[3:0] || locked !== 1'b0) begin
        errors++;
        $display("FAIL errcnt_step%0d: errcnt=%0d locked=%0b expected %0d 0", i, errcnt, locked, exp_cnt);
      end
      cyc(3'd4);
      cyc(3'd0);
      cyc(3'd1);
      cyc(3'd2);
      cyc(3'd3);
    end
    checks++;
    if (errcnt !== 4'd15 || err !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL errcnt_saturated: errcnt=%0d err=%0b locked=%0b expected 15 1 1", errcnt, err, locked);
    end
    do_reset();
    checks++;
    if (err !== 1'b0 || errcnt !== 4'd0) begin
      errors++;
      $display("FAIL err_cleared_by_reset: err=%0b errcnt=%0d expected 0 0", err, errcnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    q     = 3'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_lock_wrap();
    test_hold_fault();
    test_bad_value();
    test_wraps_saturate();
    test_reset_priority();
    test_errcnt_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter MODULUS, default 5; sequence length of the upstream counter; legal range 2..8.
REQ-002 Parameter LOCK_RUN, default 3; consecutive legal steps needed to enter LOCKED; legal range 1..7.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset; sampled on rising edge of CLK.
REQ-005 Q  input  3  count value from the upstream mod-MODULUS counter, same clock domain.
REQ-006 WRAP  output  1  one-cycle pulse on each legal wrap (MODULUS-1 -> 0) while LOCKED.
REQ-007 WRAPS  output  8  number of legal wraps seen while LOCKED, saturating.
REQ-008 LOCKED  output  1  high while the FSM is in state LOCKED.
REQ-009 ERR  output  1  sticky fault flag.
REQ-010 ERRCNT  output  4  number of LOCKED->FAULT transitions, saturating.

Function
REQ-011 All outputs SHALL be registered; each updates at the rising edge where its cause is sampled.
REQ-012 Internal register PREV (3 bits) SHALL capture Q every cycle; flag PV SHALL be set on the first non-reset cycle.
REQ-013 next(x) SHALL be 0 when x = MODULUS-1, else x+1.
REQ-014 A step SHALL be legal when PV=1, Q < MODULUS, PREV < MODULUS and Q = next(PREV); otherwise illegal; a cycle with PV=0 is neither legal nor illegal and only loads PREV.
REQ-015 A held value (Q = PREV) SHALL be illegal.
REQ-016 FSM states SHALL be UNLOCKED, LOCKED, FAULT; reset state UNLOCKED.
REQ-017 Run counter RUN (3 bits) SHALL increment on each legal step in UNLOCKED or FAULT and clear to 0 on any illegal step.
REQ-018 UNLOCKED -> LOCKED SHALL occur on the legal step that makes RUN reach LOCK_RUN; RUN clears on entry.
REQ-019 FAULT -> LOCKED SHALL occur under the same rule as REQ-018.
REQ-020 LOCKED -> FAULT SHALL occur on any illegal step; ERR set to 1 and ERRCNT incremented at that same edge.
REQ-021 In LOCKED, a legal step with PREV = MODULUS-1 and Q = 0 SHALL set WRAP=1 for exactly the following cycle and increment WRAPS.
REQ-022 WRAP SHALL be 0 in every other cycle; no WRAP and no WRAPS change in UNLOCKED or FAULT, including the step that enters LOCKED.
REQ-023 WRAPS SHALL saturate at 255; ERRCNT SHALL saturate at 15; neither wraps around.
REQ-024 ERR SHALL remain 1 after re-entry to LOCKED; only RESET clears it.
REQ-025 Any Q >= MODULUS SHALL be illegal (REQ-014) and SHALL not corrupt PREV handling on the next step.

Reset
REQ-026 RESET=1 at a rising edge SHALL force: state UNLOCKED, PV=0, PREV=0, RUN=0, WRAP=0, WRAPS=0, LOCKED=0, ERR=0, ERRCNT=0.
REQ-027 RESET SHALL take priority over every transition, including a coincident wrap or fault.
REQ-028 Reset asserted mid-operation SHALL discard all history; relock SHALL require LOCK_RUN fresh legal steps after the PV-load cycle.

Verification
REQ-029 RESET high 15 cycles with Q=0, then Q counting 0,1,2,3,4,0,... -> LOCKED=1 after the 3rd legal step, first WRAP on the first 4->0 sampled after lock, WRAPS=1.
REQ-030 Locked, Q sequence 1,2,2,3 -> FAULT at the repeated 2, ERR=1, ERRCNT=1, LOCKED=0; LOCKED=1 after 3 more legal steps, ERR still 1.
REQ-031 Locked, inject Q=6 once -> FAULT, ERRCNT=1, no WRAP in the next 3 cycles.
REQ-032 Run locked for 300 wraps (1500 cycles) -> WRAPS=255 held, WRAP still pulses each wrap.
REQ-033 RESET asserted on the same edge as a legal 4->0 while LOCKED -> WRAP=0, WRAPS=0, LOCKED=0 next cycle.
REQ-034 16 forced faults with relock between each -> ERRCNT=15 held, ERR=1.
